// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for mem_arbiter
// Contents: arbiter state encoding, transaction owner encoding, full-word byte enable.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   localparam logic [1:0] BE_WORD = 2'b11;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// rtl/mem_arbiter_sat_counter.sv - saturating up-counter with synchronous clear
// Ports:
//   i_clk   clock
//   i_rst   asynchronous active-high reset, clears count
//   i_clr   synchronous clear, has priority over i_inc
//   i_inc   increment enable; count holds once it reaches MAX
//   o_count current count
module sat_counter #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] MAX   = '1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != MAX)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master (ifetch, data) to one-slave memory arbiter
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   if_read/if_address             ifetch read request (held until if_resp)
//   if_resp/if_rdata               ifetch completion pulse and read data
//   d_read/d_write/d_byte_enable   data request (held until d_resp)
//   d_address/d_wdata              data address and write data
//   d_resp/d_rdata                 data completion pulse and read data
//   mem_*                          registered memory request, mem_resp/mem_rdata from memory
//   if_grant_cnt/d_grant_cnt       saturating completed-transaction counters
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 if_read,
   input  logic [15:0]          if_address,
   output logic                 if_resp,
   output logic [15:0]          if_rdata,
   input  logic                 d_read,
   input  logic                 d_write,
   input  logic [1:0]           d_byte_enable,
   input  logic [15:0]          d_address,
   input  logic [15:0]          d_wdata,
   output logic                 d_resp,
   output logic [15:0]          d_rdata,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [1:0]           mem_byte_enable,
   output logic [15:0]          mem_address,
   output logic [15:0]          mem_wdata,
   input  logic                 mem_resp,
   input  logic [15:0]          mem_rdata,
   output logic [CNT_WIDTH-1:0] if_grant_cnt,
   output logic [CNT_WIDTH-1:0] d_grant_cnt
);

   localparam int              SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

   state_t      r_state;
   logic        r_mem_read;
   logic        r_mem_write;
   logic [1:0]  r_mem_be;
   logic [15:0] r_mem_addr;
   logic [15:0] r_mem_wdata;

   logic          w_d_req;
   logic          w_i_done;
   logic          w_d_done;
   logic          w_force_i;
   logic          w_grant;
   owner_t        w_winner;
   logic [SW-1:0] w_starve;

   assign w_d_req  = d_read | d_write;
   // A resp only completes a transaction when one is outstanding; a stray
   // resp seen in IDLE (e.g. after reset mid-transaction) is dropped here.
   assign w_i_done = (r_state == SERVE_I) & mem_resp;
   assign w_d_done = (r_state == SERVE_D) & mem_resp;
   assign w_force_i = if_read & (w_starve == STARVE_MAX);

   always_comb begin
      w_grant  = if_read | w_d_req;
      w_winner = OWN_D;
      if (if_read && (w_force_i || !w_d_req)) begin
         w_winner = OWN_I;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_be    <= 2'b00;
         r_mem_addr  <= 16'h0000;
         r_mem_wdata <= 16'h0000;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  if (w_winner == OWN_I) begin
                     r_state     <= SERVE_I;
                     r_mem_read  <= 1'b1;
                     r_mem_write <= 1'b0;
                     r_mem_be    <= BE_WORD;
                     r_mem_addr  <= if_address;
                     r_mem_wdata <= 16'h0000;
                  end else begin
                     r_state     <= SERVE_D;
                     r_mem_read  <= d_read;
                     r_mem_write <= d_write;
                     r_mem_be    <= d_byte_enable;
                     r_mem_addr  <= d_address;
                     r_mem_wdata <= d_wdata;
                  end
               end
            end
            SERVE_I, SERVE_D: begin
               if (mem_resp) begin
                  r_state     <= IDLE;
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_mem_read  <= 1'b0;
               r_mem_write <= 1'b0;
            end
         endcase
      end
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_if_cnt (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_clr   (1'b0),
      .i_inc   (w_i_done),
      .o_count (if_grant_cnt)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_d_cnt (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_clr   (1'b0),
      .i_inc   (w_d_done),
      .o_count (d_grant_cnt)
   );

   // Counts data completions that overtook a waiting ifetch; any ifetch
   // completion or an idle ifetch port resets the tally.
   sat_counter #(.WIDTH(SW), .MAX(STARVE_MAX)) u_starve_cnt (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_clr   (~if_read | w_i_done),
      .i_inc   (w_d_done & if_read),
      .o_count (w_starve)
   );

   assign mem_read        = r_mem_read;
   assign mem_write       = r_mem_write;
   assign mem_byte_enable = r_mem_be;
   assign mem_address     = r_mem_addr;
   assign mem_wdata       = r_mem_wdata;

   assign if_resp  = w_i_done;
   assign d_resp   = w_d_done;
   assign if_rdata = mem_rdata;
   assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_read;
   logic [15:0] if_address;
   logic        if_resp;
   logic [15:0] if_rdata;
   logic        d_read;
   logic        d_write;
   logic [1:0]  d_byte_enable;
   logic [15:0] d_address;
   logic [15:0] d_wdata;
   logic        d_resp;
   logic [15:0] d_rdata;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_byte_enable;
   logic [15:0] mem_address;
   logic [15:0] mem_wdata;
   logic        mem_resp;
   logic [15:0] mem_rdata;
   logic [15:0] if_grant_cnt;
   logic [15:0] d_grant_cnt;

   logic        mem_auto;
   logic        man_resp;
   logic        m_resp;
   logic [15:0] m_rdata;
   logic [15:0] mem [0:255];

   int checks = 0;
   int errors = 0;

   bit          resp_kind[$];
   logic [15:0] resp_data[$];

   always #5 clk = ~clk;

   mem_arbiter u_dut (
      .clk             (clk),
      .reset           (reset),
      .if_read         (if_read),
      .if_address      (if_address),
      .if_resp         (if_resp),
      .if_rdata        (if_rdata),
      .d_read          (d_read),
      .d_write         (d_write),
      .d_byte_enable   (d_byte_enable),
      .d_address       (d_address),
      .d_wdata         (d_wdata),
      .d_resp          (d_resp),
      .d_rdata         (d_rdata),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_byte_enable (mem_byte_enable),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_resp        (mem_resp),
      .mem_rdata       (mem_rdata),
      .if_grant_cnt    (if_grant_cnt),
      .d_grant_cnt     (d_grant_cnt)
   );

   assign mem_resp  = mem_auto ? m_resp : man_resp;
   assign mem_rdata = m_rdata;

   // Memory model: answers a held request one cycle after seeing it, word index = address[8:1].
   always @(posedge clk) begin
      if (reset) begin
         m_resp  <= 1'b0;
         m_rdata <= 16'h0000;
         for (int i = 0; i < 256; i++) begin
            mem[i] <= (i == 8) ? 16'h1234 : (i == 16) ? 16'h5566 : 16'(i * 257);
         end
      end else if (!mem_auto) begin
         m_resp <= 1'b0;
      end else if (m_resp) begin
         m_resp <= 1'b0;
      end else if (mem_read) begin
         m_rdata <= mem[mem_address[8:1]];
         m_resp  <= 1'b1;
      end else if (mem_write) begin
         if (mem_byte_enable[1]) mem[mem_address[8:1]][15:8] <= mem_wdata[15:8];
         if (mem_byte_enable[0]) mem[mem_address[8:1]][7:0]  <= mem_wdata[7:0];
         m_resp <= 1'b1;
      end
   end

   task automatic serve(input int budget, output bit timeout);
      timeout = 1'b1;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (if_resp) begin
            resp_kind.push_back(1'b0);
            resp_data.push_back(if_rdata);
            if_read = 1'b0;
         end
         if (d_resp) begin
            resp_kind.push_back(1'b1);
            resp_data.push_back(d_rdata);
            d_read  = 1'b0;
            d_write = 1'b0;
         end
         if (!if_read && !d_read && !d_write) begin
            timeout = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL reset_rw got %b exp 00", {mem_read, mem_write}); end
      checks++; if (mem_byte_enable !== 2'b00) begin errors++; $display("FAIL reset_be got %b exp 00", mem_byte_enable); end
      checks++; if ({mem_address, mem_wdata} !== 32'h0) begin errors++; $display("FAIL reset_addr_wdata got %h exp 0", {mem_address, mem_wdata}); end
      checks++; if ({if_resp, d_resp} !== 2'b00) begin errors++; $display("FAIL reset_resp got %b exp 00", {if_resp, d_resp}); end
      checks++; if ({if_grant_cnt, d_grant_cnt} !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0", {if_grant_cnt, d_grant_cnt}); end
      reset = 1'b0;
   endtask

   task automatic test_ifetch;
      bit to;
      resp_kind.delete(); resp_data.delete();
      @(negedge clk);
      if_address = 16'h0010;
      if_read    = 1'b1;
      #1;
      checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL if_no_comb_path got %b exp 0", mem_read); end
      @(negedge clk);
      checks++; if ({mem_read, mem_write} !== 2'b10) begin errors++; $display("FAIL if_issue_rw got %b exp 10", {mem_read, mem_write}); end
      checks++; if (mem_byte_enable !== 2'b11) begin errors++; $display("FAIL if_issue_be got %b exp 11", mem_byte_enable); end
      checks++; if ({mem_address, mem_wdata} !== {16'h0010, 16'h0000}) begin errors++; $display("FAIL if_issue_addr got %h exp 00100000", {mem_address, mem_wdata}); end
      serve(20, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL if_timeout got %b exp 0", to); end
      checks++; if (resp_kind.size() !== 1) begin errors++; $display("FAIL if_resp_count got %0d exp 1", resp_kind.size()); end
      if (resp_kind.size() == 1) begin
         checks++; if ({resp_kind[0], resp_data[0]} !== {1'b0, 16'h1234}) begin errors++; $display("FAIL if_rdata got %b/%h exp 0/1234", resp_kind[0], resp_data[0]); end
      end
      @(negedge clk);
      checks++; if ({if_grant_cnt, d_grant_cnt} !== {16'd1, 16'd0}) begin errors++; $display("FAIL if_cnt got %h exp 00010000", {if_grant_cnt, d_grant_cnt}); end
      checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL if_read_drop got %b exp 0", mem_read); end
   endtask

   task automatic test_data;
      bit to;
      resp_kind.delete(); resp_data.delete();
      d_address     = 16'h0021;
      d_byte_enable = 2'b10;
      d_wdata       = 16'hAB00;
      d_write       = 1'b1;
      @(negedge clk);
      checks++; if ({mem_read, mem_write, mem_byte_enable} !== 4'b0110) begin errors++; $display("FAIL stb_issue got %b exp 0110", {mem_read, mem_write, mem_byte_enable}); end
      checks++; if ({mem_address, mem_wdata} !== {16'h0021, 16'hAB00}) begin errors++; $display("FAIL stb_addr_wdata got %h exp 0021ab00", {mem_address, mem_wdata}); end
      serve(20, to);
      d_address     = 16'h0020;
      d_byte_enable = 2'b11;
      d_read        = 1'b1;
      serve(20, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL data_timeout got %b exp 0", to); end
      checks++; if (resp_kind.size() !== 2) begin errors++; $display("FAIL data_resp_count got %0d exp 2", resp_kind.size()); end
      if (resp_kind.size() == 2) begin
         checks++; if ({resp_kind[0], resp_kind[1], resp_data[1]} !== {2'b11, 16'hAB66}) begin errors++; $display("FAIL data_rdata got %b%b/%h exp 11/ab66", resp_kind[0], resp_kind[1], resp_data[1]); end
      end
      @(negedge clk);
      checks++; if ({if_grant_cnt, d_grant_cnt} !== {16'd1, 16'd2}) begin errors++; $display("FAIL data_cnt got %h exp 00010002", {if_grant_cnt, d_grant_cnt}); end
   endtask

   task automatic test_concurrent;
      bit to;
      resp_kind.delete(); resp_data.delete();
      if_address    = 16'h0010;
      d_address     = 16'h0020;
      d_byte_enable = 2'b11;
      if_read       = 1'b1;
      d_read        = 1'b1;
      serve(60, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL conc_timeout got %b exp 0", to); end
      checks++; if (resp_kind.size() !== 2) begin errors++; $display("FAIL conc_resp_count got %0d exp 2", resp_kind.size()); end
      if (resp_kind.size() == 2) begin
         checks++; if ({resp_kind[0], resp_kind[1]} !== 2'b10) begin errors++; $display("FAIL conc_order got %b%b exp 10 (D then I)", resp_kind[0], resp_kind[1]); end
         checks++; if ({resp_data[0], resp_data[1]} !== {16'hAB66, 16'h1234}) begin errors++; $display("FAIL conc_rdata got %h %h exp ab66 1234", resp_data[0], resp_data[1]); end
      end
      @(negedge clk);
      checks++; if ({if_grant_cnt, d_grant_cnt} !== {16'd2, 16'd3}) begin errors++; $display("FAIL conc_cnt got %h exp 00020003", {if_grant_cnt, d_grant_cnt}); end
   endtask

   task automatic test_starvation;
      logic [2:0] exp_starve [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0};
      logic [5:0] order;
      bit chk;
      int idx;
      bit done;
      resp_kind.delete(); resp_data.delete();
      chk  = 1'b0;
      done = 1'b0;
      idx  = 0;
      if_address    = 16'h0010;
      d_address     = 16'h0020;
      d_byte_enable = 2'b11;
      if_read       = 1'b1;
      d_read        = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (chk) begin
            chk = 1'b0;
            checks++; if (u_dut.w_starve !== exp_starve[idx]) begin errors++; $display("FAIL starve_cnt_%0d got %0d exp %0d", idx, u_dut.w_starve, exp_starve[idx]); end
            if (resp_kind.size() == 6) begin done = 1'b1; break; end
         end
         if (if_resp) begin
            resp_kind.push_back(1'b0);
            if_read = 1'b0;
            idx = resp_kind.size() - 1;
            chk = 1'b1;
         end
         if (d_resp) begin
            resp_kind.push_back(1'b1);
            if (resp_kind.size() >= 6) d_read = 1'b0;
            idx = resp_kind.size() - 1;
            chk = 1'b1;
         end
      end
      if_read = 1'b0;
      d_read  = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL starve_timeout got %b exp 1", done); end
      order = 6'b000000;
      for (int k = 0; k < 6 && k < resp_kind.size(); k++) order[5-k] = resp_kind[k];
      checks++; if (order !== 6'b111101) begin errors++; $display("FAIL starve_order got %b exp 111101 (D D D D I D)", order); end
      @(negedge clk);
      checks++; if ({if_grant_cnt, d_grant_cnt} !== {16'd3, 16'd8}) begin errors++; $display("FAIL starve_grant_cnt got %h exp 00030008", {if_grant_cnt, d_grant_cnt}); end
   endtask

   task automatic test_reset_mid;
      resp_kind.delete(); resp_data.delete();
      @(negedge clk);
      mem_auto      = 1'b0;
      d_address     = 16'h0030;
      d_byte_enable = 2'b01;
      d_read        = 1'b1;
      @(negedge clk);
      checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL mid_issue got %b exp 1", mem_read); end
      reset = 1'b1;
      #1;
      checks++; if ({mem_read, mem_write, mem_byte_enable} !== 4'b0000) begin errors++; $display("FAIL mid_async_clear got %b exp 0000", {mem_read, mem_write, mem_byte_enable}); end
      checks++; if ({if_grant_cnt, d_grant_cnt} !== 32'h0) begin errors++; $display("FAIL mid_cnt_clear got %h exp 0", {if_grant_cnt, d_grant_cnt}); end
      d_read = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      man_resp = 1'b1;
      #1;
      checks++; if ({if_resp, d_resp} !== 2'b00) begin errors++; $display("FAIL stray_resp got %b exp 00", {if_resp, d_resp}); end
      @(negedge clk);
      man_resp = 1'b0;
      @(negedge clk);
      checks++; if ({if_grant_cnt, d_grant_cnt, mem_read} !== 33'h0) begin errors++; $display("FAIL stray_cnt got %h exp 0", {if_grant_cnt, d_grant_cnt, mem_read}); end
      mem_auto = 1'b1;
   endtask

   task automatic test_saturation;
      bit to;
      @(negedge clk);
      u_dut.u_if_cnt.r_count = 16'hFFFE;
      for (int n = 0; n < 2; n++) begin
         resp_kind.delete(); resp_data.delete();
         if_address = 16'h0010;
         if_read    = 1'b1;
         serve(20, to);
         @(negedge clk);
         checks++; if ({to, if_grant_cnt} !== {1'b0, 16'hFFFF}) begin errors++; $display("FAIL sat_cnt_%0d got %b/%h exp 0/ffff", n, to, if_grant_cnt); end
      end
      checks++; if (d_grant_cnt !== 16'd0) begin errors++; $display("FAIL sat_d_cnt got %h exp 0000", d_grant_cnt); end
   endtask

   initial begin
      reset         = 1'b1;
      if_read       = 1'b0;
      if_address    = 16'h0000;
      d_read        = 1'b0;
      d_write       = 1'b0;
      d_byte_enable = 2'b00;
      d_address     = 16'h0000;
      d_wdata       = 16'h0000;
      mem_auto      = 1'b1;
      man_resp      = 1'b0;
      repeat (3) @(posedge clk);
      test_reset;
      test_ifetch;
      test_data;
      test_concurrent;
      test_starvation;
      test_reset_mid;
      test_saturation;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
